// File: rtl/fifo_pkg.sv
// Purpose: shared constants, data/pointer/count types and width helper for the FIFO core.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: DATA_WIDTH_DEF, DEPTH_DEF, fifo_data_t, ptr_t, cnt_t, ptr_width().
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;
    localparam int PTR_W_DEF      = $clog2(DEPTH_DEF);

    typedef logic [DATA_WIDTH_DEF-1:0] fifo_data_t;
    typedef logic [PTR_W_DEF-1:0]      ptr_t;
    // One extra bit so count can represent DEPTH itself.
    typedef logic [PTR_W_DEF:0]        cnt_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Purpose: push/pop handshake bundle between a FIFO driver (master) and the FIFO core (slave).
// Latency: n/a (wires only).
// Backpressure: master watches full/empty; dropped requests are the master's concern.
// Signals: wr_en/din/rd_en driven by master; dout and status flags driven by slave.
// Optional FIFO_ERR_FLAGS_EN adds overflow/underflow pulses driven by the slave.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, overflow, underflow
    );
    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, overflow, underflow
    );
`else
    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty
    );
    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty
    );
`endif

endinterface

// File: rtl/fifo_mem.sv
// Purpose: DEPTH x DATA_WIDTH register-array storage, one write port, one registered read port.
// Latency: write visible next cycle; rdata updates one cycle after re.
// Backpressure: none; caller only asserts we/re for accepted operations.
// Ports: clk, rst_n (read register only), we/waddr/wdata, re/raddr, rdata.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage deliberately has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value when no read is requested. A same-edge
    // write to raddr (full FIFO, push+pop) returns the old entry, as required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_core.sv
// Purpose: single-clock synchronous FIFO, storage/responder end of the fifo_if handshake.
// Latency: dout valid one cycle after an accepted pop; flags follow the registered count.
// Backpressure: push dropped when full (unless popping), pop dropped when empty.
// Ports: clk, rst_n (async, active-low), bus (fifo_if.slave: wr_en/din/rd_en in,
//        dout/full/empty/almost_full/almost_empty out).
// Optional FIFO_ERR_FLAGS_EN: adds overflow/underflow one-cycle pulses on dropped operations.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    fifo_if.slave  bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;

    // Flags depend only on the registered count, so no combinational path
    // exists from wr_en/rd_en to any status output.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_CNT);
    assign bus.almost_empty = (count <= AE_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push paired with a pop. An empty FIFO never bypasses din to dout.
    assign wr_ok = bus.wr_en && (!full || bus.rd_en);
    assign rd_ok = bus.rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (bus.dout)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Pulses describe requests rejected at the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.wr_en && !wr_ok;
            underflow_q <= bus.rd_en && !rd_ok;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Purpose: self-checking bench for sync_fifo_core against a queue-based reference model.
// Latency: model mirrors one-cycle pop latency and next-cycle flag updates.
// Backpressure: model drops pushes when full without a pop and pops when empty.
module tb_sync_fifo_core;
    import fifo_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fifo_if #(.DATA_WIDTH(8)) bus ();

    sync_fifo_core #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (14),
        .AE_LEVEL   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    fifo_data_t q[$];
    fifo_data_t m_dout;
    logic       m_ovf;
    logic       m_unf;

    // Expected {full, empty, almost_full, almost_empty} from the model occupancy.
    function automatic logic [3:0] exp_flags();
        int sz;
        sz = q.size();
        return {sz == DEPTH, sz == 0, sz >= 14, sz <= 2};
    endfunction

    // Applies one cycle of requests and advances the reference model.
    task automatic drive(input logic w, input logic r, input fifo_data_t d);
        int sz;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        @(posedge clk);
        sz    = q.size();
        m_ovf = w && !r && (sz == DEPTH);
        m_unf = r && (sz == 0);
        if (r && sz > 0) m_dout = q.pop_front();
        if (w && (sz < DEPTH || r)) q.push_back(d);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] fl;
        rst_n     = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        model_reset();
        #12;
        fl = {bus.full, bus.empty, bus.almost_full, bus.almost_empty};
        n_cmp++;
        if (fl !== 4'b0101) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0101", fl);
        end
        n_cmp++;
        if (bus.dout !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dout: got %h want 00", bus.dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'($urandom_range(1, 255)));
        drive(1'b0, 1'b1, '0);
        n_cmp++;
        if (bus.dout !== m_dout) begin
            n_err++;
            $display("FAIL pre_reset_dout: got %h want %h", bus.dout, m_dout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        fl = {bus.full, bus.empty, bus.almost_full, bus.almost_empty};
        n_cmp++;
        if (fl !== 4'b0101) begin
            n_err++;
            $display("FAIL async_reset_flags: got %b want 0101", fl);
        end
        n_cmp++;
        if (bus.dout !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset_dout: got %h want 00", bus.dout);
        end
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, '0);
        n_cmp++;
        if (bus.dout !== 8'h00 || bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_pop: got dout=%h empty=%b want 00/1", bus.dout, bus.empty);
        end
`ifdef FIFO_ERR_FLAGS_EN
        n_cmp++;
        if (bus.underflow !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_underflow: got %b want 1", bus.underflow);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            n_cmp++;
            if (bus.almost_full !== (i >= 14) || bus.full !== (i == 16)) begin
                n_err++;
                $display("FAIL fill_%0d: got af=%b full=%b want %b/%b",
                         i, bus.almost_full, bus.full, i >= 14, i == 16);
            end
        end
        drive(1'b1, 1'b0, 8'hFF);
        n_cmp++;
        if (bus.full !== 1'b1 || q.size() != 16) begin
            n_err++;
            $display("FAIL overfill: got full=%b want 1 (model size %0d)", bus.full, q.size());
        end
`ifdef FIFO_ERR_FLAGS_EN
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_pulse: got %b want 1", bus.overflow);
        end
        drive(1'b0, 1'b0, '0);
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: got %b want 0", bus.overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, '0);
            n_cmp++;
            if (bus.dout !== 8'(i) || bus.almost_empty !== (16 - i <= 2) || bus.empty !== (i == 16)) begin
                n_err++;
                $display("FAIL drain_%0d: got dout=%h ae=%b empty=%b want %h/%b/%b",
                         i, bus.dout, bus.almost_empty, bus.empty, 8'(i), 16 - i <= 2, i == 16);
            end
        end
        drive(1'b0, 1'b1, '0);
        n_cmp++;
        if (bus.dout !== 8'h10 || bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL underpop: got dout=%h empty=%b want 10/1", bus.dout, bus.empty);
        end
`ifdef FIFO_ERR_FLAGS_EN
        n_cmp++;
        if (bus.underflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_pulse: got %b want 1", bus.underflow);
        end
`endif
    endtask

    task automatic test_full_both();
        fifo_data_t first;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'($urandom));
        first = q[0];
        drive(1'b1, 1'b1, 8'hAA);
        n_cmp++;
        if (bus.dout !== first || bus.full !== 1'b1) begin
            n_err++;
            $display("FAIL full_both: got dout=%h full=%b want %h/1", bus.dout, bus.full, first);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, '0);
            n_cmp++;
            if (bus.dout !== m_dout) begin
                n_err++;
                $display("FAIL full_both_drain_%0d: got %h want %h", i, bus.dout, m_dout);
            end
        end
        n_cmp++;
        if (bus.dout !== 8'hAA) begin
            n_err++;
            $display("FAIL full_both_last: got %h want aa", bus.dout);
        end
    endtask

    task automatic test_empty_both();
        fifo_data_t prev;
        logic [3:0] fl;
        prev = m_dout;
        drive(1'b1, 1'b1, 8'h55);
        fl = {bus.full, bus.empty, bus.almost_full, bus.almost_empty};
        n_cmp++;
        if (fl !== 4'b0001 || bus.dout !== prev) begin
            n_err++;
            $display("FAIL empty_both: got flags=%b dout=%h want 0001/%h", fl, bus.dout, prev);
        end
`ifdef FIFO_ERR_FLAGS_EN
        n_cmp++;
        if (bus.underflow !== 1'b1) begin
            n_err++;
            $display("FAIL empty_both_underflow: got %b want 1", bus.underflow);
        end
`endif
        drive(1'b0, 1'b1, '0);
        n_cmp++;
        if (bus.dout !== 8'h55 || bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL empty_both_pop: got dout=%h empty=%b want 55/1", bus.dout, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fl;
        logic       w;
        logic       r;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'($urandom));
        // 40 alternating cycles, then a random mix that also hits full/empty.
        for (int c = 0; c < 340; c++) begin
            if (c < 40) begin
                w = (c % 2 == 0);
                r = !w;
            end else if (c < 190) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            drive(w, r, 8'($urandom));
            fl = {bus.full, bus.empty, bus.almost_full, bus.almost_empty};
            n_cmp++;
            if (fl !== exp_flags() || bus.dout !== m_dout) begin
                n_err++;
                $display("FAIL b2b_cycle_%0d: got flags=%b dout=%h want %b/%h",
                         c, fl, bus.dout, exp_flags(), m_dout);
            end
`ifdef FIFO_ERR_FLAGS_EN
            n_cmp++;
            if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                n_err++;
                $display("FAIL b2b_err_%0d: got ovf=%b unf=%b want %b/%b",
                         c, bus.overflow, bus.underflow, m_ovf, m_unf);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_both();
        test_empty_both();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
